// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: request encodings,
// RV32I width codes, FSM states and byte-lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } req_op_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
        S_RESP
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Bit position of the least significant bit of a byte / half lane (little-endian).
    function automatic logic [4:0] byte_lsb(input logic [1:0] off);
        return {off, 3'b000};
    endfunction

    function automatic logic [4:0] half_lsb(input logic hi);
        return {hi, 4'b0000};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_sel  = rdata[byte_lsb(off) +: BYTE_W];
        half_sel  = rdata[half_lsb(off[1]) +: HALF_W];
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            F3_LH:   load_data = {{(XLEN-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {{(XLEN-BYTE_W){1'b0}}, byte_sel};
            F3_LHU:  load_data = {{(XLEN-HALF_W){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged = wdata;
        case (funct3)
            F3_SB: begin
                merged = rdata;
                merged[byte_lsb(off) +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            F3_SH: begin
                merged = rdata;
                merged[half_lsb(off[1]) +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Requester-side RV32I data-memory controller: request checking, load/store/clear
// sequencing with read-modify-write for sub-word stores, and registered memory port.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_delete,
    output logic              mem_state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_e          state;
    req_op_e         op_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] wdata_q;
    logic            req_err;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;

    always_comb begin
        req_err = |req_addr[XLEN-1:ADDR_W+2];
        case (req_op)
            OP_LOAD: begin
                case (req_funct3)
                    F3_LB, F3_LBU: ;
                    F3_LH, F3_LHU: if (req_addr[0]) req_err = 1'b1;
                    F3_LW:         if (|req_addr[1:0]) req_err = 1'b1;
                    default:       req_err = 1'b1;
                endcase
            end
            OP_STORE: begin
                case (req_funct3)
                    F3_SB: ;
                    F3_SH:   if (req_addr[0]) req_err = 1'b1;
                    F3_SW:   if (|req_addr[1:0]) req_err = 1'b1;
                    default: req_err = 1'b1;
                endcase
            end
            OP_CLEAR: if (|req_addr[1:0]) req_err = 1'b1;
            default:  req_err = 1'b1;
        endcase
    end

    dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .rdata     (mem_rdata),
        .wdata     (wdata_q),
        .funct3    (funct3_q),
        .off       (off_q),
        .load_data (load_data),
        .merged    (merged_word)
    );

    // Every port and handshake output is a flop loaded with the value for the
    // state being entered, so nothing on the memory port depends on req_* directly.
    // NOTE: state is updated with non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_LOAD;
            funct3_q   <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_state  <= 1'b1;
            mem_delete <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            mem_state  <= 1'b1;
            mem_delete <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op_e'(req_op);
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        mem_addr  <= req_addr[ADDR_W+1:2];
                        rsp_rdata <= '0;
                        rsp_err   <= req_err;
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            case (req_op)
                                OP_LOAD: state <= S_READ;
                                OP_STORE: begin
                                    if (req_funct3 == F3_SW) begin
                                        state     <= S_WRITE;
                                        mem_state <= 1'b0;
                                        mem_wdata <= req_wdata;
                                    end else begin
                                        state <= S_READ;
                                    end
                                end
                                OP_CLEAR: begin
                                    state      <= S_CLEAR;
                                    mem_delete <= 1'b1;
                                end
                                default: begin
                                    state     <= S_RESP;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_READ: begin
                    if (op_q == OP_LOAD) begin
                        rsp_rdata <= load_data;
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        mem_wdata <= merged_word;
                        state     <= S_WRITE;
                        mem_state <= 1'b0;
                    end
                end
                S_WRITE, S_CLEAR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with a word-memory model
// and a response scoreboard.
module tb_dmem_access_unit;

    localparam int ADDR_W = 5;
    localparam int XLEN   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_delete;
    logic              mem_state;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    dmem_access_unit #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_delete (mem_delete),
        .mem_state  (mem_state),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised data memory driven by the DUT port.
    logic [XLEN-1:0] mem [2**ADDR_W];
    initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_delete)      mem[mem_addr] <= '0;
        else if (!mem_state) mem[mem_addr] <= mem_wdata;
    end

    // Port activity observed mid-cycle.
    int              wr_cnt = 0;
    int              del_cnt = 0;
    logic [XLEN-1:0] last_wr_data = '0;
    logic [31:0]     last_wr_addr = '0;
    logic [31:0]     last_del_addr = '0;
    always @(negedge clk) begin
        if (!mem_state) begin
            wr_cnt++;
            last_wr_data = mem_wdata;
            last_wr_addr = 32'(mem_addr);
        end
        if (mem_delete) begin
            del_cnt++;
            last_del_addr = 32'(mem_addr);
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_wr, input int exp_del, input logic [31:0] exp_mdata,
                          input int stall);
        int   wr0, del0, lat, wait_cyc;
        logic got;
        exp_t e;
        wait_cyc = 0;
        @(negedge clk);
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!req_ready) begin
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
            return;
        end
        rsp_ready  = (stall == 0);
        req_valid  = 1'b1;
        req_op     = op;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        wr0  = wr_cnt;
        del0 = del_cnt;
        @(posedge clk);
        #1;
        // A store presented while busy must be ignored.
        req_valid  = 1'b1;
        req_op     = 2'b01;
        req_funct3 = 3'd2;
        req_addr   = 32'h0;
        req_wdata  = 32'hDEAD_BEEF;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
            if (lat == 1) begin
                req_valid  = 1'b0;
                req_op     = 2'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (!got) return;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_stall_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        @(posedge clk);
        #1;
        check({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({tag, "_del_cycles"}, 32'(del_cnt - del0), 32'(exp_del));
        if (exp_wr != 0) begin
            check({tag, "_wr_addr"}, last_wr_addr, 32'(addr[ADDR_W+1:2]));
            check({tag, "_wr_data"}, last_wr_data, exp_mdata);
        end
        if (exp_del != 0) check({tag, "_del_addr"}, last_del_addr, 32'(addr[ADDR_W+1:2]));
    endtask

    initial begin
        int wr0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_state", 32'(mem_state), 32'd1);
        check("rst_mem_delete", 32'(mem_delete), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // tag, op, f3, addr, wdata, exp_rdata, exp_err, lat, wr, del, mdata, stall
        do_req("sw_08",   2'b01, 3'd2, 32'h08, 32'hF000000F, 32'h0,        1'b0, 2, 1, 0, 32'hF000000F, 0);
        do_req("lw_08",   2'b00, 3'd2, 32'h08, 32'h0,        32'hF000000F, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("sb_09",   2'b01, 3'd0, 32'h09, 32'h000000AB, 32'h0,        1'b0, 3, 1, 0, 32'hF000AB0F, 0);
        do_req("lb_09",   2'b00, 3'd0, 32'h09, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lbu_09",  2'b00, 3'd4, 32'h09, 32'h0,        32'h000000AB, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lh_0a",   2'b00, 3'd1, 32'h0A, 32'h0,        32'hFFFFF000, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lhu_0a",  2'b00, 3'd5, 32'h0A, 32'h0,        32'h0000F000, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("clr_08",  2'b10, 3'd0, 32'h08, 32'h0,        32'h0,        1'b0, 2, 0, 1, 32'h0,        0);
        do_req("lw_08z",  2'b00, 3'd2, 32'h08, 32'h0,        32'h0,        1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lw_06",   2'b00, 3'd2, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("sh_03",   2'b01, 3'd1, 32'h03, 32'h1234,     32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("lw_80",   2'b00, 3'd2, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("clr_0a",  2'b10, 3'd0, 32'h0A, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("ld_f3_3", 2'b00, 3'd3, 32'h00, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("st_f3_4", 2'b01, 3'd4, 32'h04, 32'h55,       32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("op_rsvd", 2'b11, 3'd2, 32'h04, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
        do_req("sw_0c",   2'b01, 3'd2, 32'h0C, 32'h11223344, 32'h0,        1'b0, 2, 1, 0, 32'h11223344, 0);
        do_req("sh_0e",   2'b01, 3'd1, 32'h0E, 32'h7777BEEF, 32'h0,        1'b0, 3, 1, 0, 32'hBEEF3344, 0);
        do_req("lh_0e",   2'b00, 3'd1, 32'h0E, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lbu_0d",  2'b00, 3'd4, 32'h0D, 32'h0,        32'h00000033, 1'b0, 2, 0, 0, 32'h0,        0);
        do_req("lw_stall",2'b00, 3'd2, 32'h0C, 32'h0,        32'hBEEF3344, 1'b0, 2, 0, 0, 32'h0,        3);

        // Reset during the READ cycle of an SH: its WRITE must never appear.
        @(negedge clk);
        check("rr_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_op     = 2'b01;
        req_funct3 = 3'd1;
        req_addr   = 32'h0C;
        req_wdata  = 32'h0000AAAA;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rr_req_ready", 32'(req_ready), 32'd1);
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_rsp_rdata", rsp_rdata, 32'd0);
        check("rr_rsp_err", 32'(rsp_err), 32'd0);
        check("rr_mem_state", 32'(mem_state), 32'd1);
        check("rr_mem_delete", 32'(mem_delete), 32'd0);
        check("rr_mem_addr", 32'(mem_addr), 32'd0);
        check("rr_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        check("rr_no_write", 32'(wr_cnt - wr0), 32'd0);
        do_req("lw_after_rst", 2'b00, 3'd2, 32'h0C, 32'h0, 32'hBEEF3344, 1'b0, 2, 0, 0, 32'h0, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
